// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared types and constants for the buffered PS/2 scancode path.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    typedef struct packed {
        logic       extended;
        logic       released;
        logic [7:0] code;
    } ps2_event_t;

    // Bit positions inside the KBSTATUS register
    localparam int ST_BSY  = 7;
    localparam int ST_OVF  = 6;
    localparam int ST_FULL = 5;
    localparam int ST_ERR  = 4;
    localparam int ST_RLS  = 3;
    localparam int ST_EXT  = 2;
    localparam int ST_RSV  = 1;
    localparam int ST_PEN  = 0;

    localparam logic [7:0] c_scancode_addr_def = 8'h04;
    localparam logic [7:0] c_kbstatus_addr_def = 8'h05;

endpackage
`default_nettype wire

// File: rtl/ps2_scancode_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : ps2_scancode_fifo_if
// Description : PS/2 event input, ZX-Uno register bus and status signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface ps2_scancode_fifo_if #(
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);

    logic        scan_received;
    logic [7:0]  scancode;
    logic        extended;
    logic        released;
    logic        ps2busy;
    logic        kberror;
    logic [7:0]  zxuno_addr;
    logic        zxuno_regrd;
    logic [7:0]  scancode_dout;
    logic        oe_n_scancode;
    logic [7:0]  kbstatus_dout;
    logic        oe_n_kbstatus;
    logic [AW:0] fifo_count;
    logic        hotkey_pulse;

    modport master (
        output scan_received, scancode, extended, released, ps2busy, kberror,
               zxuno_addr, zxuno_regrd,
        input  scancode_dout, oe_n_scancode, kbstatus_dout, oe_n_kbstatus,
               fifo_count, hotkey_pulse
    );

    modport slave (
        input  scan_received, scancode, extended, released, ps2busy, kberror,
               zxuno_addr, zxuno_regrd,
        output scancode_dout, oe_n_scancode, kbstatus_dout, oe_n_kbstatus,
               fifo_count, hotkey_pulse
    );
endinterface
`default_nettype wire

// File: rtl/ps2_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_event_fifo
// Description : Generic DEPTH x WIDTH synchronous FIFO with show-ahead head.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = $bits(ps2_event_t)
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    input  wire logic                       i_push,
    input  wire logic [WIDTH-1:0]           i_data,
    input  wire logic                       i_pop,
    output logic      [WIDTH-1:0]           o_head,
    output logic                            o_full,
    output logic                            o_empty,
    output logic      [$clog2(DEPTH):0]     o_count
);
    localparam int              AW     = $clog2(DEPTH);
    localparam logic [AW:0]     c_full = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_full    = (r_count == c_full);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/ps2_scancode_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_scancode_fifo
// Description : Buffered PS/2 event queue behind the ZX-Uno SCANCODE/KBSTATUS
//               registers. Define PS2_HOTKEY_EN to enable the hotkey detector.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_scancode_fifo
    import ps2_pkg::*;
#(
    parameter int         DEPTH         = 8,
    parameter logic [7:0] SCANCODE_ADDR = c_scancode_addr_def,
    parameter logic [7:0] KBSTATUS_ADDR = c_kbstatus_addr_def,
    parameter logic [7:0] HOTKEY_CODE   = 8'h7E
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    ps2_scancode_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    ps2_event_t  w_head;
    ps2_event_t  w_push_data;
    logic        w_full;
    logic        w_empty;
    logic [AW:0] w_count;
    logic        w_pop;
    logic        w_sc_sel;
    logic        w_kb_sel;
    logic        w_sc_end;
    logic        w_kb_end;
    logic [7:0]  w_status;

    logic r_sc_active;
    logic r_sc_idle;
    logic r_kb_active;
    logic r_kb_idle;
    logic r_ovf;
    logic r_bsy;
    logic r_err;

    assign w_sc_sel = bus.zxuno_regrd && (bus.zxuno_addr == SCANCODE_ADDR);
    assign w_kb_sel = bus.zxuno_regrd && (bus.zxuno_addr == KBSTATUS_ADDR);
    assign bus.oe_n_scancode = !w_sc_sel;
    assign bus.oe_n_kbstatus = !w_kb_sel;

    // A read only counts once its start (idle -> selected) has been observed,
    // so a read already in progress across reset never produces a read-end.
    assign w_sc_end = !w_sc_sel && r_sc_active;
    assign w_kb_end = !w_kb_sel && r_kb_active;
    assign w_pop    = w_sc_end && !w_empty;

    assign w_push_data = '{extended: bus.extended, released: bus.released, code: bus.scancode};

    ps2_event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(ps2_event_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (bus.scan_received),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sc_active <= 1'b0;
            r_sc_idle   <= 1'b0;
            r_kb_active <= 1'b0;
            r_kb_idle   <= 1'b0;
            r_ovf       <= 1'b0;
            r_bsy       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_sc_idle   <= !w_sc_sel;
            r_sc_active <= w_sc_sel && (r_sc_active || r_sc_idle);
            r_kb_idle   <= !w_kb_sel;
            r_kb_active <= w_kb_sel && (r_kb_active || r_kb_idle);
            r_bsy       <= bus.ps2busy;
            r_err       <= bus.kberror;
            // Set has priority over the read-end clear
            if (bus.scan_received && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end else if (w_kb_end) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_comb begin
        w_status          = 8'h00;
        w_status[ST_BSY]  = r_bsy;
        w_status[ST_OVF]  = r_ovf;
        w_status[ST_FULL] = w_full;
        w_status[ST_ERR]  = r_err;
        w_status[ST_RLS]  = !w_empty && w_head.released;
        w_status[ST_EXT]  = !w_empty && w_head.extended;
        w_status[ST_PEN]  = !w_empty;
    end

    assign bus.kbstatus_dout = w_status;
    assign bus.scancode_dout = w_empty ? 8'h00 : w_head.code;
    assign bus.fifo_count    = w_count;

`ifdef PS2_HOTKEY_EN
    logic r_hotkey;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hotkey <= 1'b0;
        end else begin
            r_hotkey <= bus.scan_received && (bus.scancode == HOTKEY_CODE)
                        && !bus.extended && !bus.released;
        end
    end

    assign bus.hotkey_pulse = r_hotkey;
`else
    logic w_unused_hotkey;
    assign w_unused_hotkey  = ^HOTKEY_CODE;
    assign bus.hotkey_pulse = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_ps2_scancode_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_scancode_fifo
// Description : Scoreboard bench for ps2_scancode_fifo (DEPTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_scancode_fifo;
    localparam int         DEPTH = 8;
    localparam logic [7:0] SC_A  = 8'h04;
    localparam logic [7:0] KB_A  = 8'h05;
`ifdef PS2_HOTKEY_EN
    localparam logic       HK_EN = 1'b1;
`else
    localparam logic       HK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ps2_scancode_fifo_if #(.DEPTH(DEPTH)) bus ();

    ps2_scancode_fifo #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [9:0] q[$];
    logic       exp_ovf = 1'b0;
    int         n_pass  = 0;
    int         n_total = 0;

    // Push one event; model the FIFO as a queue bounded at DEPTH
    task automatic send(input logic [7:0] c, input logic e, input logic r,
                        output logic hk1, output logic hk2);
        @(negedge clk);
        bus.scan_received = 1'b1; bus.scancode = c; bus.extended = e; bus.released = r;
        if (q.size() < DEPTH) q.push_back({e, r, c}); else exp_ovf = 1'b1;
        @(negedge clk);
        hk1 = bus.hotkey_pulse;
        bus.scan_received = 1'b0;
        @(negedge clk);
        hk2 = bus.hotkey_pulse;
    endtask

    task automatic do_read(input logic [7:0] addr, input int hold,
                           output logic [7:0] sc, output logic [7:0] st);
        @(negedge clk);
        bus.zxuno_addr = addr; bus.zxuno_regrd = 1'b1;
        repeat (hold) @(negedge clk);
        sc = bus.scancode_dout; st = bus.kbstatus_dout;
        bus.zxuno_regrd = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        n_total++; if (bus.fifo_count !== 4'd0) $display("FAIL rst_count: got %0d want 0", bus.fifo_count); else n_pass++;
        n_total++; if (bus.scancode_dout !== 8'h00) $display("FAIL rst_dout: got %h want 00", bus.scancode_dout); else n_pass++;
        n_total++; if (bus.kbstatus_dout !== 8'h00) $display("FAIL rst_status: got %h want 00", bus.kbstatus_dout); else n_pass++;
        n_total++; if (bus.hotkey_pulse !== 1'b0) $display("FAIL rst_hotkey: got %b want 0", bus.hotkey_pulse); else n_pass++;
        bus.zxuno_addr = KB_A; bus.zxuno_regrd = 1'b1; #1;
        n_total++; if ({bus.oe_n_scancode, bus.oe_n_kbstatus} !== 2'b10) $display("FAIL oe_decode: got %b want 10", {bus.oe_n_scancode, bus.oe_n_kbstatus}); else n_pass++;
        bus.zxuno_regrd = 1'b0; #1;
        n_total++; if ({bus.oe_n_scancode, bus.oe_n_kbstatus} !== 2'b11) $display("FAIL oe_idle: got %b want 11", {bus.oe_n_scancode, bus.oe_n_kbstatus}); else n_pass++;
    endtask

    task automatic test_status_passthru;
        @(negedge clk); bus.ps2busy = 1'b1; bus.kberror = 1'b1;
        @(negedge clk);
        n_total++; if ({bus.kbstatus_dout[7], bus.kbstatus_dout[4]} !== 2'b11) $display("FAIL bsy_err: got %b want 11", {bus.kbstatus_dout[7], bus.kbstatus_dout[4]}); else n_pass++;
        bus.ps2busy = 1'b0; bus.kberror = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic hk1, hk2; logic [7:0] sc, st; logic [9:0] exp;
        send(8'h1C, 1'b0, 1'b0, hk1, hk2);
        send(8'h1C, 1'b1, 1'b0, hk1, hk2);
        send(8'h1C, 1'b0, 1'b1, hk1, hk2);
        n_total++; if (bus.fifo_count !== 4'd3) $display("FAIL basic_count: got %0d want 3", bus.fifo_count); else n_pass++;
        do_read(KB_A, 2, sc, st);
        n_total++; if ({st[0], st[2], st[3]} !== 3'b100) $display("FAIL basic_status: got %h want PEN=1 EXT=0 RLS=0", st); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            do_read(SC_A, 2, sc, st);
            exp = (q.size() != 0) ? q.pop_front() : 10'h000;
            n_total++; if ({st[2], st[3], sc} !== exp) $display("FAIL basic_read%0d: got ext=%b rls=%b code=%h want %h", i, st[2], st[3], sc, exp); else n_pass++;
        end
        n_total++; if (bus.kbstatus_dout[0] !== 1'b0) $display("FAIL basic_pen: got %b want 0", bus.kbstatus_dout[0]); else n_pass++;
    endtask

    task automatic test_overflow;
        logic hk1, hk2; logic [7:0] sc, st; logic [9:0] exp;
        for (int i = 1; i <= 9; i++) send(8'(i), 1'b0, 1'b0, hk1, hk2);
        n_total++; if (bus.fifo_count !== 4'd8) $display("FAIL ovf_count: got %0d want 8", bus.fifo_count); else n_pass++;
        n_total++; if ({bus.kbstatus_dout[5], bus.kbstatus_dout[6]} !== {1'b1, exp_ovf}) $display("FAIL ovf_flags: got full=%b ovf=%b want 1 %b", bus.kbstatus_dout[5], bus.kbstatus_dout[6], exp_ovf); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            do_read(SC_A, 1, sc, st);
            exp = (q.size() != 0) ? q.pop_front() : 10'h000;
            n_total++; if ({st[2], st[3], sc, st[6]} !== {exp, exp_ovf}) $display("FAIL ovf_read%0d: got code=%h ovf=%b want %h ovf=%b", i, sc, st[6], exp[7:0], exp_ovf); else n_pass++;
        end
        do_read(SC_A, 1, sc, st);
        n_total++; if (sc !== 8'h00) $display("FAIL ovf_lost: got %h want 00", sc); else n_pass++;
        do_read(KB_A, 1, sc, st);
        n_total++; if (st[6] !== exp_ovf) $display("FAIL ovf_before_clear: got %b want %b", st[6], exp_ovf); else n_pass++;
        exp_ovf = 1'b0;
        n_total++; if (bus.kbstatus_dout[6] !== exp_ovf) $display("FAIL ovf_clear: got %b want %b", bus.kbstatus_dout[6], exp_ovf); else n_pass++;
    endtask

    task automatic test_full_pushpop;
        logic hk1, hk2; logic [7:0] sc, st; logic [9:0] exp;
        for (int i = 0; i < 8; i++) send(8'h30 + 8'(i), 1'b0, 1'b0, hk1, hk2);
        @(negedge clk); bus.zxuno_addr = SC_A; bus.zxuno_regrd = 1'b1;
        @(negedge clk);
        exp = q.pop_front();
        n_total++; if (bus.scancode_dout !== exp[7:0]) $display("FAIL fpp_head: got %h want %h", bus.scancode_dout, exp[7:0]); else n_pass++;
        bus.zxuno_regrd = 1'b0;
        bus.scan_received = 1'b1; bus.scancode = 8'h55; bus.extended = 1'b0; bus.released = 1'b0;
        q.push_back(10'h055);
        @(negedge clk); bus.scan_received = 1'b0;
        n_total++; if ({bus.fifo_count, bus.kbstatus_dout[6]} !== {4'd8, 1'b0}) $display("FAIL fpp_count_ovf: got %0d ovf=%b want 8 ovf=0", bus.fifo_count, bus.kbstatus_dout[6]); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            do_read(SC_A, 1, sc, st);
            exp = (q.size() != 0) ? q.pop_front() : 10'h000;
            n_total++; if (sc !== exp[7:0]) $display("FAIL fpp_read%0d: got %h want %h", i, sc, exp[7:0]); else n_pass++;
        end
    endtask

    task automatic test_empty_read;
        logic hk1, hk2; logic [7:0] sc, st; logic [9:0] exp;
        do_read(SC_A, 10, sc, st);
        n_total++; if ({sc, bus.fifo_count} !== {8'h00, 4'd0}) $display("FAIL empty_read: got %h cnt=%0d want 00 cnt=0", sc, bus.fifo_count); else n_pass++;
        send(8'h11, 1'b0, 1'b0, hk1, hk2);
        send(8'h22, 1'b0, 1'b0, hk1, hk2);
        do_read(SC_A, 10, sc, st);
        exp = q.pop_front();
        n_total++; if ({sc, bus.fifo_count} !== {exp[7:0], 4'd1}) $display("FAIL long_read: got %h cnt=%0d want %h cnt=1", sc, bus.fifo_count, exp[7:0]); else n_pass++;
        do_read(SC_A, 1, sc, st);
        exp = q.pop_front();
        n_total++; if (sc !== exp[7:0]) $display("FAIL long_read_next: got %h want %h", sc, exp[7:0]); else n_pass++;
    endtask

    task automatic test_hotkey;
        logic hk1, hk2; logic [7:0] sc, st; logic [9:0] exp;
        send(8'h7E, 1'b0, 1'b0, hk1, hk2);
        n_total++; if ({hk1, hk2} !== {HK_EN, 1'b0}) $display("FAIL hk_make: got %b%b want %b0", hk1, hk2, HK_EN); else n_pass++;
        send(8'h7E, 1'b0, 1'b1, hk1, hk2);
        n_total++; if ({hk1, hk2} !== 2'b00) $display("FAIL hk_break: got %b%b want 00", hk1, hk2); else n_pass++;
        send(8'h7E, 1'b1, 1'b0, hk1, hk2);
        n_total++; if ({hk1, hk2} !== 2'b00) $display("FAIL hk_ext: got %b%b want 00", hk1, hk2); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            do_read(SC_A, 1, sc, st);
            exp = (q.size() != 0) ? q.pop_front() : 10'h000;
            n_total++; if ({st[2], st[3], sc} !== exp) $display("FAIL hk_read%0d: got ext=%b rls=%b code=%h want %h", i, st[2], st[3], sc, exp); else n_pass++;
        end
    endtask

    task automatic test_reset_midread;
        logic hk1, hk2; logic [7:0] sc, st; logic [9:0] exp;
        for (int i = 0; i < 5; i++) send(8'h41 + 8'(i), 1'b0, 1'b0, hk1, hk2);
        @(negedge clk); bus.zxuno_addr = SC_A; bus.zxuno_regrd = 1'b1;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        q.delete(); exp_ovf = 1'b0;
        n_total++; if ({bus.fifo_count, bus.kbstatus_dout, bus.scancode_dout} !== {4'd0, 8'h00, 8'h00}) $display("FAIL mid_reset: got cnt=%0d st=%h dout=%h want 0 00 00", bus.fifo_count, bus.kbstatus_dout, bus.scancode_dout); else n_pass++;
        send(8'h66, 1'b0, 1'b0, hk1, hk2);
        bus.zxuno_regrd = 1'b0;
        repeat (3) @(negedge clk);
        n_total++; if ({bus.fifo_count, bus.scancode_dout} !== {4'd1, 8'h66}) $display("FAIL stale_read_end: got cnt=%0d dout=%h want 1 66", bus.fifo_count, bus.scancode_dout); else n_pass++;
        do_read(SC_A, 1, sc, st);
        exp = q.pop_front();
        n_total++; if ({sc, bus.fifo_count} !== {exp[7:0], 4'd0}) $display("FAIL post_reset_read: got %h cnt=%0d want %h cnt=0", sc, bus.fifo_count, exp[7:0]); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.scan_received = 1'b0; bus.scancode = 8'h00; bus.extended = 1'b0; bus.released = 1'b0;
        bus.ps2busy = 1'b0; bus.kberror = 1'b0; bus.zxuno_addr = 8'h00; bus.zxuno_regrd = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_status_passthru();
        test_basic();
        test_overflow();
        test_full_pushpop();
        test_empty_read();
        test_hotkey();
        test_reset_midread();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ps2_scancode_fifo.md
# ps2_scancode_fifo

Buffered successor to the single-register keyboard status path. It captures every decoded PS/2 event (scancode plus extended/released flags) from the PS/2 receiver into a parametrised FIFO, and serves the ZX-Uno SCANCODE and KBSTATUS registers from the FIFO head. Reads pop one entry, so bursts such as E0-prefixed make/break sequences are not lost while the CPU is slow to poll. A configurable hotkey detector replaces the hard-wired ScrollLock video toggle.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; power of two, 2..64.
- SCANCODE_ADDR, 8'h04: ZX-Uno register address of the scancode register.
- KBSTATUS_ADDR, 8'h05: ZX-Uno register address of the status register.
- HOTKEY_CODE, 8'h7E: non-extended make code that fires hotkey_pulse.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- scan_received  in  1  one-cycle strobe from the PS/2 receiver; a new event is valid.
- scancode  in  8  event code, valid with scan_received.
- extended  in  1  E0 prefix flag, valid with scan_received.
- released  in  1  F0 break flag, valid with scan_received.
- ps2busy  in  1  host-to-keyboard transmitter busy; passed through to status.
- kberror  in  1  host-to-keyboard error; passed through to status.
- zxuno_addr  in  8  selected ZX-Uno register.
- zxuno_regrd  in  1  ZX-Uno register read strobe (level, may span many cycles).
- scancode_dout  out  8  head entry code; 8'h00 when empty.
- oe_n_scancode  out  1  low while addr==SCANCODE_ADDR and regrd==1.
- kbstatus_dout  out  8  {BSY, OVF, FULL, ERR, RLS, EXT, 1'b0, PEN}.
- oe_n_kbstatus  out  1  low while addr==KBSTATUS_ADDR and regrd==1.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.
- hotkey_pulse  out  1  one-cycle pulse on the hotkey make event.

## Operation
- Entry format: 10 bits, {extended, released, code}.
- Push: on scan_received, when the FIFO is not full or a pop occurs in the same cycle.
- Push while full with no same-cycle pop: the new event is dropped and OVF is set. Existing entries are preserved.
- Pop: occurs on the read-end cycle, meaning the first cycle where oe_n_scancode is high after being low. The pop happens only if the FIFO is non-empty.
- A read on an empty FIFO returns 8'h00 and does not pop.
- Status bits:
  - PEN = FIFO non-empty.
  - FULL = count==DEPTH.
  - RLS and EXT come from the head entry; both are 0 when empty.
  - BSY and ERR are registered copies of ps2busy and kberror.
- OVF is sticky. It clears on the read-end cycle of a KBSTATUS read. If a new overflow occurs in that same cycle, OVF stays set (set wins).
- Pointers are AW=$clog2(DEPTH) bits wide and wrap modulo DEPTH. Count is kept as a separate AW+1-bit counter.
- Simultaneous push and pop: count is unchanged, both pointers advance, and the data stays coherent. This holds when full and in every other state where a pop is legal.
- Pushes and pops never affect hotkey detection.

## Timing
- All outputs are registered except oe_n_* and scancode_dout/RLS/EXT, which are combinational from the head storage.
- Reset values:
  - scancode_dout=8'h00.
  - kbstatus_dout=8'h00.
  - fifo_count=0.
  - hotkey_pulse=0.
  - Pointers and OVF are 0.
  - oe_n_* follow their inputs.
- Latency from scan_received at cycle N:
  - PEN=1 and head data visible at cycle N+1.
  - fifo_count is updated at N+1.
  - hotkey_pulse is high during N+1 only.
- Pop at read-end cycle R: the next entry (or empty) is visible at R+1.
- The output value is held for the entire duration of a regrd level.
- rst_n asserted mid-read or mid-burst empties the FIFO immediately. Any read-end edge seen after reset release is ignored until a new read begins.

## Configuration
- PS2_HOTKEY_EN defined: hotkey_pulse is driven as described. It fires on code==HOTKEY_CODE && !extended && !released, independent of FIFO fullness.
- PS2_HOTKEY_EN undefined: the comparator and its register are removed, and hotkey_pulse is tied to 0.

## Structure
- Shared package ps2_pkg:
  - ps2_event_t struct {extended, released, code[7:0]}.
  - Status bit index constants (ST_BSY=7 … ST_PEN=0).
  - Default register addresses 8'h04/8'h05.
- One sub-module: ps2_event_fifo. It is a generic DEPTH×10-bit synchronous FIFO with push, pop, full, empty and count outputs.
- Register decode, read-end edge detection, OVF and hotkey logic live in the top module.

## Test plan
- Reset, then three events (0x1C make, 0x1C E0 make, 0x1C break) → fifo_count=3. The KBSTATUS read reports PEN=1, EXT=0, RLS=0. Three SCANCODE reads return 0x1C each, with EXT=1 on the 2nd and RLS=1 on the 3rd. After the 3rd read, PEN=0.
- DEPTH=8: push 9 events 0x01..0x09 → FULL=1 and OVF=1. Reads return 0x01..0x08; 0x09 is lost. OVF clears after the next KBSTATUS read-end.
- Full FIFO, with scan_received=0x55 in the same cycle as a SCANCODE read-end → count stays 8, no OVF, and 0x55 is the 8th entry read.
- SCANCODE read while empty → dout=0x00, count stays 0, no pointer change. A regrd held for 10 cycles pops exactly once.
- With PS2_HOTKEY_EN: 0x7E make → one-cycle hotkey_pulse. 0x7E break and E0 0x7E → no pulse. Without the macro, hotkey_pulse stays 0.
- rst_n low for 1 cycle with 5 entries queued and regrd active → count=0 and status=0x00. Releasing regrd after reset causes no pop, and the count does not underflow.
